// File: rtl/vga_pkg.sv
// Shared VGA constants, colour types and the per-axis bounce rule for the bouncing-text source.
package vga_pkg;

  localparam int unsigned H_VALID   = 640;
  localparam int unsigned V_VALID   = 480;
  localparam int unsigned CHAR_W    = 16;
  localparam int unsigned CHAR_H    = 32;
  localparam int unsigned NUM_CHARS = 8;
  localparam int unsigned BOX_W     = NUM_CHARS * CHAR_W;
  localparam int unsigned STEP      = 1;
  localparam int unsigned BOX_X0    = 256;
  localparam int unsigned BOX_Y0    = 224;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned ARITH_W   = 11;
  localparam int unsigned CI_W      = $clog2(NUM_CHARS);
  localparam int unsigned COL_W     = $clog2(CHAR_W);
  localparam int unsigned ROW_W     = $clog2(CHAR_H);
  localparam int unsigned DX_W      = CI_W + COL_W;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BG_COLOR = 16'h0000;
  localparam rgb565_t PALETTE [0:7] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                                       16'hF81F, 16'h07FF, 16'hFFFF, 16'hFD20};

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               neg;
    logic               bounce;
  } axis_t;

  // One frame of motion on one axis; clamps to the wall and reverses when the next step would cross it.
  function automatic axis_t axis_step(input logic [COORD_W-1:0] pos, input logic neg,
                                      input int unsigned active, input int unsigned extent);
    axis_t              r;
    logic [ARITH_W-1:0] far;
    r.pos    = pos;
    r.neg    = neg;
    r.bounce = 1'b0;
    far      = ARITH_W'(pos) + ARITH_W'(extent) + ARITH_W'(STEP);
    if (!neg) begin
      if (far > ARITH_W'(active)) begin
        r.pos    = COORD_W'(active - extent);
        r.neg    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + COORD_W'(STEP);
      end
    end else if (pos < COORD_W'(STEP)) begin
      r.pos    = '0;
      r.neg    = 1'b0;
      r.bounce = 1'b1;
    end else begin
      r.pos = pos - COORD_W'(STEP);
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_char_font_rom.sv
// Combinational glyph ROM for "BOUNCE!!": 8x8 source glyphs scaled 2x wide and 4x tall,
// with every fourth line blanked for a scanline look.
module vga_char_font_rom
  import vga_pkg::*;
(
  input  logic [CI_W-1:0]   ci,
  input  logic [ROW_W-1:0]  row,
  output logic [CHAR_W-1:0] row_bits_c
);

  logic [63:0] glyph_c;
  logic [7:0]  byte_c;

  always_comb begin
    glyph_c    = '0;
    byte_c     = '0;
    row_bits_c = '0;
    case (ci)
      3'd0:    glyph_c = 64'hFC66667C6666FC00;
      3'd1:    glyph_c = 64'h3C66C3C3C3663C00;
      3'd2:    glyph_c = 64'hC6C6C6C6C6C67C00;
      3'd3:    glyph_c = 64'hC6E6F6DECEC6C600;
      3'd4:    glyph_c = 64'h3C66C0C0C0663C00;
      3'd5:    glyph_c = 64'hFE6268786862FE00;
      default: glyph_c = 64'h183C3C1818001800;
    endcase
    // Source row 0 lives in the top byte.
    byte_c = 8'(glyph_c >> {3'd7 - row[4:2], 3'b000});
    if (row[1:0] != 2'b11) begin
      for (int i = 0; i < 8; i++) begin
        row_bits_c[2*i +: 2] = {2{byte_c[i]}};
      end
    end
  end

endmodule

// File: rtl/vga_char_bounce_pic.sv
// Pixel source: a bouncing line of glyphs, recoloured on every wall hit, one-cycle registered output.
module vga_char_bounce_pic
  import vga_pkg::*;
(
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_data
);

  logic [COORD_W-1:0] box_x_q, box_x_d;
  logic [COORD_W-1:0] box_y_q, box_y_d;
  logic               dir_x_neg_q, dir_x_neg_d;
  logic               dir_y_neg_q, dir_y_neg_d;
  logic [2:0]         color_idx_q, color_idx_d;
  rgb565_t            pix_data_q, pix_data_d;

  logic               tick_c;
  logic               in_range_c;
  logic               in_box_c;
  logic [DX_W-1:0]    dx_c;
  logic [ROW_W-1:0]   dy_c;
  logic [CHAR_W-1:0]  row_bits_c;
  logic               lit_c;
  axis_t              ax_c, ay_c;

  assign tick_c     = (pix_x == COORD_W'(H_VALID - 1)) && (pix_y == COORD_W'(V_VALID - 1));
  assign in_range_c = (pix_x < COORD_W'(H_VALID)) && (pix_y < COORD_W'(V_VALID));
  assign in_box_c   = (pix_x >= box_x_q) && (ARITH_W'(pix_x) < ARITH_W'(box_x_q) + ARITH_W'(BOX_W)) &&
                      (pix_y >= box_y_q) && (ARITH_W'(pix_y) < ARITH_W'(box_y_q) + ARITH_W'(CHAR_H));
  assign dx_c       = DX_W'(pix_x - box_x_q);
  assign dy_c       = ROW_W'(pix_y - box_y_q);
  assign pix_data   = pix_data_q;

  vga_char_font_rom u_font_rom (
    .ci         (dx_c[COL_W +: CI_W]),
    .row        (dy_c),
    .row_bits_c (row_bits_c)
  );

  // Leftmost pixel of a glyph column maps to the MSB of the font word.
  assign lit_c = row_bits_c[COL_W'(CHAR_W - 1) - dx_c[COL_W-1:0]];

  always_comb begin
    pix_data_d = 16'h0000;
    if (in_range_c) begin
      pix_data_d = (in_box_c && lit_c) ? PALETTE[color_idx_q] : BG_COLOR;
    end
  end

  // Motion advances only on the frame tick; the tick pixel itself still sees the old box.
  always_comb begin
    ax_c        = axis_step(box_x_q, dir_x_neg_q, H_VALID, BOX_W);
    ay_c        = axis_step(box_y_q, dir_y_neg_q, V_VALID, CHAR_H);
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    color_idx_d = color_idx_q;
    if (tick_c) begin
      box_x_d     = ax_c.pos;
      box_y_d     = ay_c.pos;
      dir_x_neg_d = ax_c.neg;
      dir_y_neg_d = ay_c.neg;
      color_idx_d = color_idx_q + 3'(ax_c.bounce | ay_c.bounce);
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      box_x_q     <= COORD_W'(BOX_X0);
      box_y_q     <= COORD_W'(BOX_Y0);
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      color_idx_q <= '0;
      pix_data_q  <= 16'h0000;
    end else begin
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
      color_idx_q <= color_idx_d;
      pix_data_q  <= pix_data_d;
    end
  end

endmodule

// File: tb/tb_vga_char_bounce_pic.sv
// Bench for vga_char_bounce_pic: directed corner probes plus random pixels against a behavioural model.
module tb_vga_char_bounce_pic;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: box origin, direction flags, palette index, frames seen.
  int m_bx, m_by, m_xneg, m_yneg, m_color, frames;

  logic [15:0] pal [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                           16'hF81F, 16'h07FF, 16'hFFFF, 16'hFD20};
  logic [63:0] font [8] = '{64'hFC66667C6666FC00, 64'h3C66C3C3C3663C00,
                            64'hC6C6C6C6C6C67C00, 64'hC6E6F6DECEC6C600,
                            64'h3C66C0C0C0663C00, 64'hFE6268786862FE00,
                            64'h183C3C1818001800, 64'h183C3C1818001800};

  vga_char_bounce_pic dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 256; m_by = 224; m_xneg = 0; m_yneg = 0; m_color = 0; frames = 0;
  endtask

  function automatic logic [15:0] exp_pix(input int x, input int y);
    int dx, row, ci, col;
    logic [63:0] g;
    if (x >= 640 || y >= 480) return 16'h0000;
    if (x < m_bx || x >= m_bx + 128 || y < m_by || y >= m_by + 32) return 16'h0000;
    dx  = x - m_bx;
    ci  = dx / 16;
    col = dx % 16;
    row = y - m_by;
    g   = font[ci];
    if (row % 4 == 3) return 16'h0000;
    if (g[63 - 8 * (row / 4) - col / 2]) return pal[m_color];
    return 16'h0000;
  endfunction

  task automatic model_tick();
    int bounce;
    bounce = 0;
    if (m_xneg == 0) begin
      if (m_bx + 128 + 1 > 640) begin m_bx = 512; m_xneg = 1; bounce = 1; end
      else m_bx = m_bx + 1;
    end else begin
      if (m_bx < 1) begin m_bx = 0; m_xneg = 0; bounce = 1; end
      else m_bx = m_bx - 1;
    end
    if (m_yneg == 0) begin
      if (m_by + 32 + 1 > 480) begin m_by = 448; m_yneg = 1; bounce = 1; end
      else m_by = m_by + 1;
    end else begin
      if (m_by < 1) begin m_by = 0; m_yneg = 0; bounce = 1; end
      else m_by = m_by - 1;
    end
    if (bounce != 0) m_color = (m_color + 1) % 8;
    frames++;
  endtask

  // Present one pixel request, check the registered result one edge later, then apply any frame tick.
  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input string tag);
    logic [15:0] e;
    e     = exp_pix(int'(x), int'(y));
    pix_x = x;
    pix_y = y;
    @(posedge vga_clk);
    #1;
    check(tag, pix_data, e);
    if (x == 10'd639 && y == 10'd479) model_tick();
  endtask

  task automatic rand_pix(output logic [9:0] x, output logic [9:0] y);
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) begin
      x = 10'($urandom_range(640, 1023)); y = 10'($urandom_range(0, 1023));
    end else if (k == 1) begin
      x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(480, 1023));
    end else if (k <= 6) begin
      x = 10'(m_bx - 2 + int'($urandom_range(0, 131)));
      y = 10'(m_by - 2 + int'($urandom_range(0, 35)));
    end else begin
      x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
    end
  endtask

  initial begin
    logic [9:0] rx, ry;
    sys_rst_n = 1'b0;
    pix_x     = 10'd256;
    pix_y     = 10'd224;
    model_reset();

    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_hold_box", pix_data, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      pix_x = 10'($urandom_range(0, 1023));
      pix_y = 10'($urandom_range(0, 1023));
      @(posedge vga_clk);
      #1;
      check("rst_hold_rand", pix_data, 16'h0000);
    end
    @(negedge vga_clk);
    sys_rst_n = 1'b1;

    drive_pix(10'd256, 10'd224, "origin_lit");
    check("origin_f800", pix_data, 16'hF800);
    drive_pix(10'd255, 10'd224, "left_of_box");
    check("left_bg", pix_data, 16'h0000);
    drive_pix(10'd383, 10'd255, "box_far_corner");
    drive_pix(10'd384, 10'd224, "right_of_box");

    drive_pix(10'h3FF, 10'd100, "x_3ff");
    check("x_3ff_zero", pix_data, 16'h0000);
    drive_pix(10'd100, 10'h3FF, "y_3ff");
    drive_pix(10'd640, 10'd0, "x_640");
    check("x_640_zero", pix_data, 16'h0000);
    drive_pix(10'd0, 10'd480, "y_480");

    drive_pix(10'd639, 10'd479, "tick1");
    drive_pix(10'd256, 10'd224, "old_origin");
    check("old_origin_bg", pix_data, 16'h0000);
    drive_pix(10'd257, 10'd225, "new_origin");
    check("new_origin_f800", pix_data, 16'hF800);

    while (frames < 225) drive_pix(10'd639, 10'd479, "tick_run");
    drive_pix(10'd481, 10'd448, "ybounce_origin");
    check("ybounce_color1", pix_data, 16'h07E0);
    drive_pix(10'd481, 10'd447, "ybounce_above");
    while (frames < 257) drive_pix(10'd639, 10'd479, "tick_run");
    drive_pix(10'd512, 10'd416, "xbounce_origin");
    check("xbounce_color2", pix_data, 16'h001F);
    drive_pix(10'd639, 10'd416, "xbounce_edge");

    for (int f = 0; f < 600; f++) begin
      for (int p = 0; p < 15; p++) begin
        rand_pix(rx, ry);
        drive_pix(rx, ry, "rand_pix");
      end
      if (f == 300) begin
        drive_pix(10'(m_bx), 10'(m_by), "pre_rst_origin");
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_zero", pix_data, 16'h0000);
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        model_reset();
        drive_pix(10'd256, 10'd224, "post_rst_origin");
        check("post_rst_f800", pix_data, 16'hF800);
      end
      drive_pix(10'd639, 10'd479, "rand_tick");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
